// File: rtl/plru_pkg.sv
`default_nettype none
// ============================================================================
// Module      : plru_pkg
// Description : Shared types and tree pseudo-LRU helpers for plru_array.
//               Trees are passed zero-extended to MAX_TREE_W bits and ways to
//               MAX_WAY_W bits. 'levels' is log2(number of ways).
//               Node 0 is the root. Node n has child 2n+1 for the lower half
//               and child 2n+2 for the upper half. A bit of 0 points the
//               victim to the lower half.
//               Both maxima carry one spare bit, so a caller's unused upper
//               slice is never zero-width, even at 16 ways.
// Revision    : 1.0 - initial release
// ============================================================================
package plru_pkg;

  localparam int MAX_LEVELS = 4;
  localparam int MAX_TREE_W = 16;
  localparam int MAX_WAY_W  = 5;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  // Point every node on the path of 'way' away from it.
  // Node (d, p) sits at depth d, position p, and has index (2^d - 1 + p).
  // It is on the path when the top d bits of the way equal p.
  function automatic logic [MAX_TREE_W-1:0] plru_touch(
    input logic [MAX_TREE_W-1:0] tree,
    input logic [MAX_WAY_W-1:0]  way,
    input int                    levels
  );
    logic [MAX_TREE_W-1:0] t;
    int                    wi;
    t  = tree;
    wi = int'(way);
    for (int d = 0; d < MAX_LEVELS; d++) begin
      for (int p = 0; p < (1 << d); p++) begin
        if (d < levels && (wi >> (levels - d)) == p) begin
          t[(1 << d) - 1 + p] = (((wi >> (levels - d - 1)) & 1) == 0);
        end
      end
    end
    return t;
  endfunction

  // Walk from the root and build the victim one bit per level.
  function automatic logic [MAX_WAY_W-1:0] plru_victim(
    input logic [MAX_TREE_W-1:0] tree,
    input int                    levels
  );
    int   pre;
    logic b;
    pre = 0;
    for (int d = 0; d < MAX_LEVELS; d++) begin
      b = 1'b0;
      for (int p = 0; p < (1 << d); p++) begin
        if (d < levels && pre == p) begin
          b = tree[(1 << d) - 1 + p];
        end
      end
      if (d < levels) begin
        pre = 2 * pre + (b ? 1 : 0);
      end
    end
    return MAX_WAY_W'(pre);
  endfunction

endpackage
`default_nettype wire

// File: rtl/plru_set.sv
`default_nettype none
// ============================================================================
// Module      : plru_set
// Description : Tree-bit register row for one cache set.
//               Clear has priority over write.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous active-low reset, clears the row
//               wr_en    - load wr_tree at the clock edge
//               wr_tree  - new tree bits
//               clr      - synchronous clear of the row
//               tree     - current tree bits
// Revision    : 1.0 - initial release
// ============================================================================
module plru_set
  import plru_pkg::*;
#(
  parameter int TREE_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [TREE_W-1:0] wr_tree,
  input  logic              clr,
  output logic [TREE_W-1:0] tree
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tree <= '0;
    end else if (clr) begin
      tree <= '0;
    end else if (wr_en) begin
      tree <= wr_tree;
    end
  end

endmodule
`default_nettype wire

// File: rtl/plru_array.sv
`default_nettype none
// ============================================================================
// Module      : plru_array
// Description : Per-set tree pseudo-LRU replacement state.
//               The cache controller uses two operations:
//               - touch: marks (set, way) most-recently-used.
//               - lookup: returns the victim way one cycle later.
//               A lookup that hits the set touched in the same cycle sees
//               the post-touch tree.
//               Optional feature macro: PLRU_FLUSH_EN. It adds a whole-array
//               clear sequencer that clears one set per cycle, and adds the
//               flush_req and busy ports.
// Ports       : clk                  - clock, rising edge
//               rst                  - asynchronous active-low reset
//               touch_valid/set/way  - touch request
//               lookup_valid/set     - victim request
//               victim_valid/way     - registered victim, one-cycle pulse
//               flush_req            - start array clear (PLRU_FLUSH_EN)
//               busy                 - clear in progress (PLRU_FLUSH_EN)
//               ready                - touch/lookup accepted this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module plru_array
  import plru_pkg::*;
#(
  parameter int NUM_SETS = 64,
  parameter int NUM_WAYS = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        touch_valid,
  input  logic [$clog2(NUM_SETS)-1:0] touch_set,
  input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
  input  logic                        lookup_valid,
  input  logic [$clog2(NUM_SETS)-1:0] lookup_set,
  output logic                        victim_valid,
  output logic [$clog2(NUM_WAYS)-1:0] victim_way,
`ifdef PLRU_FLUSH_EN
  input  logic                        flush_req,
  output logic                        busy,
`endif
  output logic                        ready
);

  localparam int SET_W  = $clog2(NUM_SETS);
  localparam int WAY_W  = $clog2(NUM_WAYS);
  localparam int TREE_W = NUM_WAYS - 1;

  logic [TREE_W-1:0]           rows [NUM_SETS];
  logic [NUM_SETS-1:0]         clr_en;
  logic                        touch_fire;
  logic                        lookup_fire;
  logic [TREE_W-1:0]           touch_tree;
  logic [TREE_W-1:0]           lookup_tree;
  logic [WAY_W-1:0]            victim_next;
  logic [MAX_TREE_W-1:TREE_W]  touch_unused;
  logic [MAX_WAY_W-1:WAY_W]    victim_unused;

  assign touch_fire  = touch_valid & ready;
  assign lookup_fire = lookup_valid & ready;

  // Read-modify-write of the touched row. When the lookup hits the same set,
  // it reads the forwarded post-touch tree.
  always_comb begin
    {touch_unused, touch_tree} = plru_touch(
      {{(MAX_TREE_W-TREE_W){1'b0}}, rows[touch_set]},
      {{(MAX_WAY_W-WAY_W){1'b0}}, touch_way},
      WAY_W);
    lookup_tree = (touch_fire && (touch_set == lookup_set)) ? touch_tree
                                                            : rows[lookup_set];
    {victim_unused, victim_next} = plru_victim(
      {{(MAX_TREE_W-TREE_W){1'b0}}, lookup_tree}, WAY_W);
  end

  for (genvar s = 0; s < NUM_SETS; s++) begin : g_set
    plru_set #(
      .TREE_W (TREE_W)
    ) u_set (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (touch_fire && (touch_set == SET_W'(s))),
      .wr_tree (touch_tree),
      .clr     (clr_en[s]),
      .tree    (rows[s])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      victim_valid <= 1'b0;
      victim_way   <= '0;
    end else begin
      victim_valid <= lookup_fire;
      if (lookup_fire) begin
        victim_way <= victim_next;
      end
    end
  end

`ifdef PLRU_FLUSH_EN
  flush_state_e      state;
  flush_state_e      state_next;
  logic [SET_W-1:0]  flush_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == FLUSH) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (flush_req) state_next = FLUSH;
      FLUSH:   if (flush_cnt == SET_W'(NUM_SETS - 1)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // A flush request in IDLE takes priority: touch and lookup are refused
  // in that same cycle.
  always_comb begin
    busy   = (state == FLUSH);
    ready  = (state == IDLE) && !flush_req;
    clr_en = '0;
    if (state == FLUSH) begin
      clr_en[flush_cnt] = 1'b1;
    end
  end
`else
  assign ready  = 1'b1;
  assign clr_en = '0;
`endif

endmodule
`default_nettype wire
